// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory initiator.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  // RV32 load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32 store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// EXU request, WBU response and data-memory bus of the LSU front end.
interface lsu_mem_initiator_if #(
  parameter int unsigned XLEN = 32
);

  // EXU -> LSU request
  logic            in_valid;
  logic            in_ready;
  logic            in_wen;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;

  // LSU -> WBU response
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rdata;
  logic            out_err;

  // LSU -> data memory
  logic            mem_valid;
  logic            mem_wen;
  logic [7:0]      mem_wmask;
  logic [XLEN-1:0] mem_raddr;
  logic [XLEN-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  // LSU side
  modport master (
    input  in_valid, in_wen, in_funct3, in_addr, in_wdata,
    input  out_ready, mem_rdata,
    output in_ready, out_valid, out_rdata, out_err,
    output mem_valid, mem_wen, mem_wmask, mem_raddr, mem_waddr, mem_wdata
  );

  // EXU / WBU / memory side
  modport slave (
    output in_valid, in_wen, in_funct3, in_addr, in_wdata,
    output out_ready, mem_rdata,
    input  in_ready, out_valid, out_rdata, out_err,
    input  mem_valid, mem_wen, mem_wmask, mem_raddr, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: request legality, store byte mask and data
// shifting, and load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  // request side (evaluated at acceptance)
  input  logic            req_wen,
  input  logic [2:0]      req_funct3,
  input  logic [1:0]      req_off,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_legal,
  output logic [3:0]      req_wmask,
  output logic [XLEN-1:0] req_wdata_sh,
  // load side (evaluated when the memory word is valid)
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shifted;

  // Access legality: known funct3 and natural alignment for its size
  always_comb begin
    req_legal = 1'b0;
    if (req_wen) begin
      case (req_funct3)
        F3_SB:   req_legal = 1'b1;
        F3_SH:   req_legal = ~req_off[0];
        F3_SW:   req_legal = (req_off == 2'b00);
        default: req_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        F3_LB, F3_LBU: req_legal = 1'b1;
        F3_LH, F3_LHU: req_legal = ~req_off[0];
        F3_LW:         req_legal = (req_off == 2'b00);
        default:       req_legal = 1'b0;
      endcase
    end
  end

  // Store byte-enable mask within the addressed word
  always_comb begin
    req_wmask = '0;
    if (req_wen) begin
      case (req_funct3)
        F3_SB:   req_wmask = 4'b0001 << req_off;
        F3_SH:   req_wmask = 4'b0011 << req_off;
        F3_SW:   req_wmask = 4'b1111;
        default: req_wmask = '0;
      endcase
    end
  end

  // Move right-justified store data onto its byte lanes
  always_comb begin
    req_wdata_sh = req_wdata << {req_off, 3'b000};
  end

  // Right-justify the addressed lanes, then extend to XLEN
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LH:   ld_data = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU front end: accepts one EXU load/store at a time, issues a single
// word-aligned memory strobe, waits MEM_LATENCY cycles and returns the
// extended result (or an error) to WBU.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned XLEN        = lsu_pkg::XLEN
) (
  input  logic                clock,
  input  logic                reset,
  lsu_mem_initiator_if.master bus
);

  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  lsu_state_t      state;
  logic [CW-1:0]   cnt;

  // captured request
  logic            req_wen;
  logic [2:0]      req_funct3;
  logic [1:0]      req_off;

  // memory-side registers, loaded only for legal requests
  logic            mem_wen_q;
  logic [3:0]      mem_wmask_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;

  // response registers
  logic [XLEN-1:0] out_rdata_q;
  logic            out_err_q;

  logic            al_legal;
  logic [3:0]      al_wmask;
  logic [XLEN-1:0] al_wdata_sh;
  logic [XLEN-1:0] al_ld_data;

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .req_wen      (bus.in_wen),
    .req_funct3   (bus.in_funct3),
    .req_off      (bus.in_addr[1:0]),
    .req_wdata    (bus.in_wdata),
    .req_legal    (al_legal),
    .req_wmask    (al_wmask),
    .req_wdata_sh (al_wdata_sh),
    .ld_funct3    (req_funct3),
    .ld_off       (req_off),
    .ld_rdata     (bus.mem_rdata),
    .ld_data      (al_ld_data)
  );

  // Request FSM, latency counter and all captured/response state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req_wen     <= 1'b0;
      req_funct3  <= '0;
      req_off     <= '0;
      mem_wen_q   <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            req_wen    <= bus.in_wen;
            req_funct3 <= bus.in_funct3;
            req_off    <= bus.in_addr[1:0];
            if (al_legal) begin
              // lane shifting is resolved here so the bus is stable from REQ on
              mem_wen_q   <= bus.in_wen;
              mem_wmask_q <= al_wmask;
              mem_addr_q  <= {bus.in_addr[XLEN-1:2], 2'b00};
              mem_wdata_q <= al_wdata_sh;
              state       <= ST_REQ;
            end else begin
              out_rdata_q <= '0;
              out_err_q   <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          cnt   <= CW'(MEM_LATENCY - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            out_rdata_q <= req_wen ? '0 : al_ld_data;
            out_err_q   <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; mem_valid is a one-cycle strobe by construction
  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.mem_valid = (state == ST_REQ);
    bus.out_valid = (state == ST_RESP);
    bus.out_rdata = out_rdata_q;
    bus.out_err   = out_err_q;
    bus.mem_wen   = mem_wen_q;
    bus.mem_wmask = {4'b0000, mem_wmask_q};
    bus.mem_raddr = mem_addr_q;
    bus.mem_waddr = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: two instances (MEM_LATENCY 1
// and 3) share stimulus; a behavioural model predicts each access.
module tb_lsu_mem_initiator;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  // shared stimulus
  logic        t_sel;
  logic        t_valid;
  logic        t_wen;
  logic [2:0]  t_f3;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] t_rdata;
  logic        t_ordy;

  lsu_mem_initiator_if #(.XLEN(32)) b1 ();
  lsu_mem_initiator_if #(.XLEN(32)) b3 ();

  lsu_mem_initiator #(.MEM_LATENCY(1), .XLEN(32)) dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b1.master)
  );

  lsu_mem_initiator #(.MEM_LATENCY(3), .XLEN(32)) dut3 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b3.master)
  );

  assign b1.in_valid  = t_valid & ~t_sel;
  assign b3.in_valid  = t_valid & t_sel;
  assign b1.in_wen    = t_wen;
  assign b3.in_wen    = t_wen;
  assign b1.in_funct3 = t_f3;
  assign b3.in_funct3 = t_f3;
  assign b1.in_addr   = t_addr;
  assign b3.in_addr   = t_addr;
  assign b1.in_wdata  = t_wdata;
  assign b3.in_wdata  = t_wdata;
  assign b1.out_ready = t_ordy;
  assign b3.out_ready = t_ordy;
  assign b1.mem_rdata = t_rdata;
  assign b3.mem_rdata = t_rdata;

  // selected-instance view
  logic        s_ir, s_ov, s_err, s_mv, s_mwen;
  logic [7:0]  s_wmask;
  logic [31:0] s_rdata, s_raddr, s_waddr, s_wdata;
  assign s_ir    = t_sel ? b3.in_ready  : b1.in_ready;
  assign s_ov    = t_sel ? b3.out_valid : b1.out_valid;
  assign s_err   = t_sel ? b3.out_err   : b1.out_err;
  assign s_rdata = t_sel ? b3.out_rdata : b1.out_rdata;
  assign s_mv    = t_sel ? b3.mem_valid : b1.mem_valid;
  assign s_mwen  = t_sel ? b3.mem_wen   : b1.mem_wen;
  assign s_wmask = t_sel ? b3.mem_wmask : b1.mem_wmask;
  assign s_raddr = t_sel ? b3.mem_raddr : b1.mem_raddr;
  assign s_waddr = t_sel ? b3.mem_waddr : b1.mem_waddr;
  assign s_wdata = t_sel ? b3.mem_wdata : b1.mem_wdata;

  // every output of each instance; reset value is in_ready alone
  logic [140:0] view1, view3;
  assign view1 = {b1.mem_valid, b1.mem_wen, b1.mem_wmask, b1.mem_raddr, b1.mem_waddr,
                  b1.mem_wdata, b1.out_valid, b1.out_rdata, b1.out_err, b1.in_ready};
  assign view3 = {b3.mem_valid, b3.mem_wen, b3.mem_wmask, b3.mem_raddr, b3.mem_waddr,
                  b3.mem_wdata, b3.out_valid, b3.out_rdata, b3.out_err, b3.in_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // count mem_valid high on two consecutive cycles
  int   mv_adj;
  logic pv1, pv3;
  always @(negedge clk) begin
    if (b1.mem_valid && pv1) mv_adj = mv_adj + 1;
    if (b3.mem_valid && pv3) mv_adj = mv_adj + 1;
    pv1 = b1.mem_valid;
    pv3 = b3.mem_valid;
  end

  typedef struct {
    int          pulses;
    int          pulse_k;
    int          resp_k;
    int          acc_cyc;
    logic        mwen;
    logic [7:0]  wmask;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    bit          stable;
  } obs_t;

  typedef struct {
    bit          legal;
    bit          err;
    logic [7:0]  wmask;
    logic [31:0] addr_al;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  // Reference: access size/signedness from funct3, then plain arithmetic
  function automatic exp_t model(input bit wen, input bit [2:0] f3,
                                 input bit [31:0] addr, input bit [31:0] wdata,
                                 input bit [31:0] rword);
    exp_t   e;
    int     size;
    bit     sgn;
    bit     known;
    int     off;
    longint v;
    known = 1; sgn = 0; size = 4;
    if (wen) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: known = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: known = 0;
      endcase
    end
    off       = int'(addr % 4);
    e.legal   = known && ((addr % size) == 0);
    e.err     = !e.legal;
    e.addr_al = addr - 32'(off);
    e.wmask   = wen ? 8'(((1 << size) - 1) << off) : 8'h00;
    e.wdata   = 32'(longint'(wdata) * (longint'(1) << (8 * off)));
    e.rdata   = 32'h0;
    if (e.legal && !wen) begin
      v = (longint'(rword) >> (8 * off)) % (longint'(1) << (8 * size));
      if (sgn && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  // Drive one request on the selected instance and record what the bus did.
  // rdly = cycles out_ready stays low after out_valid rises.
  task automatic run_txn(input bit sel, input bit wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rword, input int rdly, output obs_t o);
    int lat, k, stall, n;
    bit seen, done;
    lat = sel ? 3 : 1;
    o = '{default: 0};
    o.pulse_k = -1;
    o.resp_k  = -1;
    o.stable  = 1;
    t_sel = sel;
    @(negedge clk);
    n = 0;
    while (!s_ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    t_wen = wen; t_f3 = f3; t_addr = addr; t_wdata = wdata;
    t_valid = 1'b1;
    t_ordy  = (rdly == 0);
    @(posedge clk);
    #1;
    o.acc_cyc = cyc;
    t_valid = 1'b0;
    t_wen = 1'($urandom); t_f3 = 3'($urandom); t_addr = $urandom; t_wdata = $urandom;
    seen = 0; done = 0; stall = 0; k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      t_rdata = (k >= 1 + lat) ? rword : $urandom;
      if (s_mv) begin
        o.pulses++;
        if (o.pulses == 1) begin
          o.pulse_k = k; o.mwen = s_mwen; o.wmask = s_wmask;
          o.raddr = s_raddr; o.waddr = s_waddr; o.wdata = s_wdata;
        end
      end
      if (seen && !s_ov) o.stable = 0;
      if (s_ov) begin
        if (!seen) begin
          seen = 1; o.resp_k = k; o.rdata = s_rdata; o.err = s_err;
        end else if (s_rdata !== o.rdata || s_err !== o.err || s_ir !== 1'b0) begin
          o.stable = 0;
        end
        if (stall == rdly) begin
          t_ordy = 1'b1;
          @(posedge clk);
          #1;
          done = 1;
        end
        stall++;
      end
    end
    if (!done) o.resp_k = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (view1 !== 141'd1) begin
      failures++; $display("FAIL reset_lat1 got=%h want=%h", view1, 141'd1);
    end
    checks++;
    if (view3 !== 141'd1) begin
      failures++; $display("FAIL reset_lat3 got=%h want=%h", view3, 141'd1);
    end
  endtask

  task automatic test_load_basic();
    obs_t o;
    run_txn(0, 0, 3'b010, 32'h8000_0004, 32'h1234_5678, 32'hDEAD_BEEF, 0, o);
    checks++;
    if (o.pulses !== 1 || o.pulse_k !== 1) begin
      failures++; $display("FAIL lw_pulse got=%0d@%0d want=1@1", o.pulses, o.pulse_k);
    end
    checks++;
    if (o.raddr !== 32'h8000_0004 || o.wmask !== 8'h00 || o.mwen !== 1'b0) begin
      failures++; $display("FAIL lw_bus got=%h/%h/%b want=80000004/00/0", o.raddr, o.wmask, o.mwen);
    end
    checks++;
    if (o.resp_k !== 3 || o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin
      failures++; $display("FAIL lw_resp got=%0d/%h/%b want=3/deadbeef/0", o.resp_k, o.rdata, o.err);
    end
  endtask

  task automatic test_store_lane();
    obs_t o;
    run_txn(0, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, o);
    checks++;
    if (o.wmask !== 8'h08 || o.wdata !== 32'hA500_0000) begin
      failures++; $display("FAIL sb_lanes got=%h/%h want=08/a5000000", o.wmask, o.wdata);
    end
    checks++;
    if (o.waddr !== 32'h8000_0000 || o.raddr !== 32'h8000_0000 || o.mwen !== 1'b1) begin
      failures++; $display("FAIL sb_addr got=%h/%h/%b want=80000000/80000000/1", o.waddr, o.raddr, o.mwen);
    end
    checks++;
    if (o.resp_k !== 3 || o.rdata !== 32'h0 || o.err !== 1'b0) begin
      failures++; $display("FAIL sb_resp got=%0d/%h/%b want=3/0/0", o.resp_k, o.rdata, o.err);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0002, 32'h8000_0002};
    logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_txn(i[0], 0, f3s[i], adrs[i], 32'h0, 32'h8001_F080, 0, o);
      checks++;
      if (o.rdata !== want[i] || o.err !== 1'b0) begin
        failures++; $display("FAIL ld_ext%0d got=%h/%b want=%h/0", i, o.rdata, o.err, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0]  f3s  [2] = '{3'b010, 3'b011};
    logic [31:0] adrs [2] = '{32'h8000_0002, 32'h8000_0000};
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      run_txn(0, 0, f3s[i], adrs[i], 32'h0, 32'h5555_AAAA, 0, o);
      checks++;
      if (o.pulses !== 0 || o.resp_k !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
        failures++;
        $display("FAIL err%0d got=pulses%0d resp@%0d err%b %h want=pulses0 resp@1 err1 0",
                 i, o.pulses, o.resp_k, o.err, o.rdata);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [31:0] w;
    w = $urandom;
    run_txn(1, 0, 3'b010, 32'h8000_0100, 32'h0, w, 5, o);
    checks++;
    if (o.stable !== 1'b1 || o.rdata !== w || o.resp_k !== 5) begin
      failures++; $display("FAIL backpressure got=stable%b %h @%0d want=stable1 %h @5", o.stable, o.rdata, o.resp_k, w);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int   prev, adj0;
    logic [31:0] w, a;
    adj0 = mv_adj;
    for (int s = 0; s < 2; s++) begin
      prev = -1;
      for (int i = 0; i < 6; i++) begin
        w = $urandom;
        a = $urandom & 32'hFFFF_FFFC;
        run_txn(s[0], 0, 3'b010, a, 32'h0, w, 0, o);
        checks++;
        if (o.rdata !== w || o.raddr !== a) begin
          failures++; $display("FAIL b2b_data%0d_%0d got=%h/%h want=%h/%h", s, i, o.rdata, o.raddr, w, a);
        end
        if (prev >= 0) begin
          checks++;
          if (o.acc_cyc - prev !== (s == 0 ? 4 : 6)) begin
            failures++; $display("FAIL b2b_period%0d_%0d got=%0d want=%0d", s, i, o.acc_cyc - prev, (s == 0 ? 4 : 6));
          end
        end
        prev = o.acc_cyc;
      end
    end
    checks++;
    if (mv_adj !== adj0) begin
      failures++; $display("FAIL mv_gap got=%0d want=%0d", mv_adj, adj0);
    end
  endtask

  task automatic test_latency3();
    obs_t o;
    run_txn(1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, o);
    checks++;
    if (o.pulse_k !== 1 || o.resp_k !== 5 || o.rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL lat3 got=pulse@%0d resp@%0d %h want=pulse@1 resp@5 deadbeef", o.pulse_k, o.resp_k, o.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit sel, wen;
    logic [2:0] f3;
    logic [31:0] a, wd, rw;
    int lat, rdly;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom); wen = 1'($urandom); f3 = 3'($urandom);
      a = $urandom; wd = $urandom; rw = $urandom; rdly = $urandom_range(0, 2);
      lat = sel ? 3 : 1;
      e = model(wen, f3, a, wd, rw);
      run_txn(sel, wen, f3, a, wd, rw, rdly, o);
      checks++;
      if (o.pulses !== int'(e.legal)) begin
        failures++; $display("FAIL rnd%0d_pulses got=%0d want=%0d", i, o.pulses, e.legal);
      end
      if (e.legal) begin
        checks++;
        if (o.pulse_k !== 1 || o.raddr !== e.addr_al || o.waddr !== e.addr_al || o.mwen !== wen
            || o.wmask !== e.wmask || o.wdata !== e.wdata) begin
          failures++;
          $display("FAIL rnd%0d_bus got=@%0d %h %h %b %h %h want=@1 %h %h %b %h %h", i, o.pulse_k,
                   o.raddr, o.waddr, o.mwen, o.wmask, o.wdata, e.addr_al, e.addr_al, wen, e.wmask, e.wdata);
        end
      end
      checks++;
      if (o.resp_k !== (e.legal ? 2 + lat : 1) || o.rdata !== e.rdata || o.err !== e.err || o.stable !== 1'b1) begin
        failures++;
        $display("FAIL rnd%0d_resp got=@%0d %h err%b stable%b want=@%0d %h err%b stable1", i, o.resp_k,
                 o.rdata, o.err, o.stable, (e.legal ? 2 + lat : 1), e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   at, n;
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      at = (i == 0) ? 1 : 3;
      t_sel = 1'b1;
      @(negedge clk);
      n = 0;
      while (!s_ir && n < 50) begin
        @(negedge clk);
        n++;
      end
      t_wen = 1'b0; t_f3 = 3'b010; t_addr = 32'h8000_0010; t_valid = 1'b1; t_ordy = 1'b1;
      @(posedge clk);
      #1;
      t_valid = 1'b0;
      repeat (at - 1) @(posedge clk);
      #2;
      if (at == 1) begin
        checks++;
        if (b3.mem_valid !== 1'b1) begin
          failures++; $display("FAIL rst_pre_mv got=%b want=1", b3.mem_valid);
        end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (view1 !== 141'd1 || view3 !== 141'd1) begin
        failures++; $display("FAIL rst_mid%0d got=%h/%h want=%h", at, view1, view3, 141'd1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      w = $urandom;
      run_txn(1, 0, 3'b010, 32'h8000_0020, 32'h0, w, 0, o);
      checks++;
      if (o.resp_k !== 5 || o.rdata !== w || o.err !== 1'b0) begin
        failures++; $display("FAIL rst_after%0d got=@%0d %h %b want=@5 %h 0", at, o.resp_k, o.rdata, o.err, w);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; mv_adj = 0; pv1 = 0; pv3 = 0;
    t_sel = 0; t_valid = 0; t_wen = 0; t_f3 = '0; t_addr = '0; t_wdata = '0;
    t_rdata = '0; t_ordy = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_load_basic();
    test_store_lane();
    test_load_ext();
    test_errors();
    test_backpressure();
    test_latency3();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit front end that initiates accesses to the team's DPI-backed data memory block.
- Accepts one load/store request at a time from EXU over valid/ready.
- Converts the request to a word-aligned memory access: a one-cycle mem_valid pulse, byte write mask, and shifted write data.
- Waits a fixed latency, extracts and extends load data, and returns the result to WBU over valid/ready.

Parameters:
- MEM_LATENCY, 1, cycles from the mem_valid pulse to mem_rdata being valid (must be ≥1).
- XLEN, 32, address and data width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  EXU request valid.
- in_ready  out  1  high only in IDLE.
- in_wen  in  1  1 = store, 0 = load.
- in_funct3  in  3  RV32 load/store funct3.
- in_addr  in  XLEN  byte address.
- in_wdata  in  XLEN  store data, right-justified.
- out_valid  out  1  result valid to WBU.
- out_ready  in  1  WBU accepts.
- out_rdata  out  XLEN  extended load data; 0 for stores and errors.
- out_err  out  1  misaligned address or illegal funct3.
- mem_valid  out  1  access strobe; single-cycle pulse.
- mem_wen  out  1  store enable.
- mem_wmask  out  8  byte mask; bits [7:4] always 0.
- mem_raddr  out  XLEN  word-aligned read address.
- mem_waddr  out  XLEN  word-aligned write address.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rdata  in  XLEN  memory read word.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0. All outputs 0 except in_ready=1. Captured request and result registers cleared.
- Reset mid-access returns to IDLE immediately and deasserts mem_valid at once. A store whose mem_valid rising edge already occurred is not undone.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - in_ready=1. On in_valid, capture wen, funct3, addr and wdata.
  - Legality check: lw/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0.
  - Legal loads: funct3 ∈ {000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu}. Legal stores: funct3 ∈ {000 sb, 001 sh, 010 sw}.
  - Legal request → REQ. Illegal → RESP with out_err=1, out_rdata=0, and no memory activity.
- REQ (exactly one cycle):
  - mem_valid=1; mem_raddr=mem_waddr={addr[31:2],2'b00}; mem_wen=wen.
  - mem_wmask = sb:4'b0001<<off, sh:4'b0011<<off, sw:4'b1111, load:0, where off=addr[1:0].
  - mem_wdata = wdata<<(8*off).
  - Then → WAIT with counter=MEM_LATENCY-1.
- WAIT:
  - mem_valid=0. mem_* address/data outputs hold stable.
  - While counter≠0, decrement. At counter=0, register the extracted load result from mem_rdata and → RESP.
- Load extraction: shift mem_rdata right by 8*off, then:
  - lb / lh: sign-extend bit 7 / 15.
  - lbu / lhu: zero-extend.
  - lw: pass through.
- RESP:
  - out_valid=1; out_rdata and out_err held stable until out_ready.
  - On out_ready → IDLE. No new request is accepted in the same cycle.
- Latency, measured from the accept edge: mem_valid is high in cycle +1 and out_valid rises at cycle +2+MEM_LATENCY.
- Throughput: one access per 3+MEM_LATENCY cycles when out_ready=1.
- mem_valid is guaranteed low for ≥1 cycle between pulses, because the memory acts on the rising edge of mem_valid.
- in_valid deasserted while not in IDLE is ignored. Captured values are unaffected by in_* changes after acceptance.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
  - State enum lsu_state_t.
  - XLEN constant.
- One combinational sub-module lsu_align: wmask and wdata shift generation, load extraction/extension, and the legality check. The FSM, counter and registers stay in the top.

Test Plan:
- Load, MEM_LATENCY=1: lw addr=0x80000004 with mem_rdata=0xDEADBEEF → single mem_valid pulse with mem_raddr=0x80000004, mem_wmask=0; out_valid at cycle +3 with out_rdata=0xDEADBEEF, out_err=0.
- Store lane shifting: sb addr=0x80000003, wdata=0x000000A5 → mem_wmask=8'h08, mem_wdata=0xA5000000, mem_waddr=0x80000000, mem_wen=1; out_rdata=0.
- Load extension: mem_rdata=0x8001F080. lb off=0 → 0xFFFFFF80; lbu off=0 → 0x00000080; lh off=2 → 0xFFFF8001; lhu off=2 → 0x00008001.
- Errors: lw addr=0x80000002 → no mem_valid, out_valid at cycle +1 with out_err=1. funct3=3'b011 load → same.
- Backpressure and spacing:
  - Hold out_ready=0 for 5 cycles → out_valid and out_rdata stable, in_ready=0.
  - Issue back-to-back requests → mem_valid pulses separated by ≥1 low cycle.
  - Repeat with MEM_LATENCY=3 → out_valid at cycle +5.
- Reset: assert reset=0 during WAIT → all outputs reset within the same cycle. After release, a new lw completes normally.
